// File: rtl/music_pkg.sv
// Shared types and constants for the note player datapath stage.
package music_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    GAP  = 2'd2
  } state_e;

  localparam int PERIOD_W_DEF = 16;
  localparam int DUR_W_DEF    = 16;

  // A half-period of zero means the note is a rest (output held low).
  localparam int REST_PERIOD  = 0;

  // Width needed to hold the gap count; never narrower than one bit.
  function automatic int gap_cnt_w(input int gap);
    return (gap > 1) ? $clog2(gap + 1) : 1;
  endfunction

endpackage

// File: rtl/note_player_if.sv
// Note handshake bundle: the sequencer drives the note fields, the player answers with ready.
interface note_player_if
  import music_pkg::*;
#(
  parameter int PERIOD_W = PERIOD_W_DEF,
  parameter int DUR_W    = DUR_W_DEF
);

  logic                in_val;
  logic                in_rdy;
  logic [PERIOD_W-1:0] in_half_period;
  logic [DUR_W-1:0]    in_duration;

  modport master (
    output in_val,
    output in_half_period,
    output in_duration,
    input  in_rdy
  );

  modport slave (
    input  in_val,
    input  in_half_period,
    input  in_duration,
    output in_rdy
  );

endinterface

// File: rtl/note_player_tone_divider.sv
// Square-wave generator: toggles its output every half_period enabled cycles.
module tone_divider
  import music_pkg::*;
#(
  parameter int PERIOD_W = PERIOD_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [PERIOD_W-1:0] half_period,
  output logic                audio
);

  logic [PERIOD_W-1:0] cnt_q, cnt_d;
  logic                audio_q, audio_d;

  // Count 0..half_period-1 and flip the output on the terminal count;
  // a rest or a disabled divider parks both the counter and the output at 0.
  always_comb begin
    cnt_d   = cnt_q;
    audio_d = audio_q;
    if (!en || (half_period == PERIOD_W'(REST_PERIOD))) begin
      cnt_d   = '0;
      audio_d = 1'b0;
    end else if (cnt_q == (half_period - PERIOD_W'(1))) begin
      cnt_d   = '0;
      audio_d = ~audio_q;
    end else begin
      cnt_d   = cnt_q + PERIOD_W'(1);
    end
  end

  // Divider state register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q   <= '0;
      audio_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      audio_q <= audio_d;
    end
  end

  assign audio = audio_q;

endmodule

// File: rtl/note_player.sv
// Plays one handshaked note as a square wave for its duration, then a silent gap, then pulses done.
module note_player
  import music_pkg::*;
#(
  parameter int PERIOD_W   = PERIOD_W_DEF,
  parameter int DUR_W      = DUR_W_DEF,
  parameter int GAP_CYCLES = 4
) (
  input  logic         clk,
  input  logic         rst,
  note_player_if.slave in_if,
  input  logic         stop,
  output logic         audio_out,
  output logic         busy,
  output logic         done
);

  localparam int GAP_W = gap_cnt_w(GAP_CYCLES);

  state_e              state_q, state_d;
  logic [DUR_W-1:0]    dur_cnt_q, dur_cnt_d;
  logic [GAP_W-1:0]    gap_cnt_q, gap_cnt_d;
  logic [PERIOD_W-1:0] hp_q, hp_d;
  logic                done_q, done_d;
  logic                hs;
  logic                tone_en;

  assign in_if.in_rdy = (state_q == IDLE);
  assign busy         = (state_q != IDLE);
  assign done         = done_q;

  // stop wins over a pending note, so it also blocks the handshake.
  assign hs = in_if.in_val && (state_q == IDLE) && !stop;

  // Next-state logic: handshake in IDLE, duration countdown in PLAY, gap countdown in GAP.
  always_comb begin
    state_d   = state_q;
    dur_cnt_d = dur_cnt_q;
    gap_cnt_d = gap_cnt_q;
    hp_d      = hp_q;
    done_d    = 1'b0;
    if (stop) begin
      state_d   = IDLE;
      dur_cnt_d = '0;
      gap_cnt_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (hs) begin
            hp_d      = in_if.in_half_period;
            dur_cnt_d = in_if.in_duration;
            if (in_if.in_duration != '0) state_d = PLAY;
            else                         done_d  = 1'b1;
          end
        end
        PLAY: begin
          dur_cnt_d = dur_cnt_q - DUR_W'(1);
          if (dur_cnt_q == DUR_W'(1)) begin
            if (GAP_CYCLES > 0) begin
              state_d   = GAP;
              gap_cnt_d = GAP_W'(GAP_CYCLES);
            end else begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end
        end
        GAP: begin
          gap_cnt_d = gap_cnt_q - GAP_W'(1);
          if (gap_cnt_q == GAP_W'(1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // FSM and counter registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      dur_cnt_q <= '0;
      gap_cnt_q <= '0;
      hp_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      dur_cnt_q <= dur_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      hp_q      <= hp_d;
      done_q    <= done_d;
    end
  end

  // Run the divider only while staying in PLAY, so it starts from zero on
  // the first PLAY cycle and is already low on the cycle after leaving PLAY.
  assign tone_en = (state_q == PLAY) && (state_d == PLAY);

  tone_divider #(
    .PERIOD_W (PERIOD_W)
  ) u_tone (
    .clk         (clk),
    .rst         (rst),
    .en          (tone_en),
    .half_period (hp_q),
    .audio       (audio_out)
  );

endmodule

// File: tb/tb_note_player.sv
// Self-checking bench for note_player: per-cycle expected outputs and the inputs to
// drive next are queued per scenario, then replayed and compared at each falling edge.
module tb_note_player;

  localparam int GAP = 4;

  logic clk, rst, stop, audio_out, busy, done;

  note_player_if #(.PERIOD_W(16), .DUR_W(16)) bif ();

  note_player #(
    .PERIOD_W   (16),
    .DUR_W      (16),
    .GAP_CYCLES (GAP)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_if     (bif),
    .stop      (stop),
    .audio_out (audio_out),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One cycle: expected outputs, then the inputs applied for the following edge.
  typedef struct {
    logic        audio;
    logic        busy;
    logic        done;
    logic        rdy;
    logic        val;
    logic [15:0] hp;
    logic [15:0] dur;
    logic        stop;
    logic        rst;
  } cyc_t;

  // Table vector: note fields, PLAY-cycle waveform (bit k = cycle k+1), done cycle.
  typedef struct {
    logic [15:0] hp;
    logic [15:0] dur;
    logic [31:0] wave;
    int          done_at;
  } vec_t;

  cyc_t  sb[$];
  vec_t  tbl[7];
  int    checks = 0;
  int    errors = 0;
  int    cyc_no = 0;
  string tag    = "reset";

  task automatic chk(input string nm, input logic act, input logic exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s.%s cycle %0d: got %b expected %b", tag, nm, cyc_no, act, exp_v);
    end
  endtask

  function automatic cyc_t mk(input logic a, input logic b, input logic d, input logic r);
    cyc_t c;
    c.audio = a;   c.busy = b;  c.done = d;   c.rdy = r;
    c.val   = 1'b0; c.hp = 16'h5A5A; c.dur = 16'hA5A5;
    c.stop  = 1'b0; c.rst = 1'b1;
    return c;
  endfunction

  // Cycles 1..upto after the handshake edge: PLAY, then GAP, then the done cycle, then idle.
  function automatic void push_note(input int dur, input logic [31:0] wave,
                                    input int done_at, input int upto);
    for (int c = 1; c <= upto; c++) begin
      if (c <= dur)          sb.push_back(mk((c <= 32) ? wave[c-1] : 1'b0, 1'b1, 1'b0, 1'b0));
      else if (c < done_at)  sb.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0));
      else if (c == done_at) sb.push_back(mk(1'b0, 1'b0, 1'b1, 1'b1));
      else                   sb.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1));
    end
  endfunction

  function automatic void push_idle(input int n);
    for (int i = 0; i < n; i++) sb.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1));
  endfunction

  task automatic run_sb();
    cyc_t r;
    cyc_no = 0;
    while (sb.size() > 0) begin
      @(negedge clk);
      r = sb.pop_front();
      cyc_no++;
      chk("audio_out", audio_out,  r.audio);
      chk("busy",      busy,       r.busy);
      chk("done",      done,       r.done);
      chk("in_rdy",    bif.in_rdy, r.rdy);
      bif.in_val         = r.val;
      bif.in_half_period = r.hp;
      bif.in_duration    = r.dur;
      stop               = r.stop;
      rst                = r.rst;
    end
  endtask

  // Present a note for the next edge; the expected cycles must already be queued.
  task automatic present(input logic [15:0] hp, input logic [15:0] dur);
    bif.in_val         = 1'b1;
    bif.in_half_period = hp;
    bif.in_duration    = dur;
  endtask

  initial begin
    cyc_t r;
    tbl[0] = '{16'd2, 16'd8,  32'h0000_00CC, 13};
    tbl[1] = '{16'd0, 16'd5,  32'h0000_0000, 10};
    tbl[2] = '{16'd1, 16'd6,  32'h0000_002A, 11};
    tbl[3] = '{16'd3, 16'd10, 32'h0000_0238, 15};
    tbl[4] = '{16'd7, 16'd0,  32'h0000_0000, 1};
    tbl[5] = '{16'd5, 16'd1,  32'h0000_0000, 6};
    tbl[6] = '{16'd4, 16'd12, 32'h0000_00F0, 17};

    // Reset held with a valid note offered: nothing may be accepted.
    rst = 1'b0; stop = 1'b0;
    present(16'd2, 16'd8);
    for (int i = 1; i <= 2; i++) begin
      @(negedge clk);
      cyc_no = i;
      chk("audio_out", audio_out,  1'b0);
      chk("busy",      busy,       1'b0);
      chk("done",      done,       1'b0);
      chk("in_rdy",    bif.in_rdy, 1'b1);
    end
    rst = 1'b1; bif.in_val = 1'b0;
    tag = "post_reset";
    push_idle(2);
    run_sb();

    // Table-driven single notes.
    for (int i = 0; i < 7; i++) begin
      tag = $sformatf("vec%0d", i);
      push_note(int'(tbl[i].dur), tbl[i].wave, tbl[i].done_at, tbl[i].done_at + 1);
      present(tbl[i].hp, tbl[i].dur);
      run_sb();
    end

    // Back-to-back: in_val stays high with note B shown during note A; B taken on A's done cycle.
    tag = "b2b";
    push_note(8, 32'h0000_00CC, 13, 13);
    for (int i = 0; i < 13; i++) begin
      r = sb[i]; r.val = 1'b1; r.hp = 16'd1; r.dur = 16'd3; sb[i] = r;
    end
    push_note(3, 32'h0000_0002, 3 + GAP + 1, 3 + GAP + 2);
    present(16'd2, 16'd8);
    run_sb();

    // Stop during PLAY cycle 7: idle next cycle with no done pulse.
    tag = "stop_play";
    push_note(20, 32'h0000_0038, 25, 7);
    r = sb[6]; r.stop = 1'b1; sb[6] = r;
    push_idle(3);
    present(16'd3, 16'd20);
    run_sb();
    tag = "after_stop";
    push_note(8, 32'h0000_00CC, 13, 14);
    present(16'd2, 16'd8);
    run_sb();

    // Stop in IDLE beats a valid note.
    tag = "stop_idle";
    push_idle(3);
    present(16'd2, 16'd8);
    stop = 1'b1;
    run_sb();

    // Reset during the second GAP cycle: idle afterwards, no done.
    tag = "rst_gap";
    push_note(3, 32'h0000_0004, 8, 5);
    r = sb[4]; r.rst = 1'b0; sb[4] = r;
    push_idle(4);
    present(16'd2, 16'd3);
    run_sb();

    // Maximum fields: the first toggle would land after the note ends, so PLAY stays low.
    tag = "max";
    push_note(65535, 32'h0, 65535 + GAP + 1, 65535 + GAP + 2);
    present(16'hFFFF, 16'hFFFF);
    run_sb();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run still active at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/note_player.md
Name: note_player

Overview:
- Downstream consumer of the registered note fields (half-period, duration) in the music-player datapath.
- Accepts one note per valid/ready handshake and plays it as a square wave for a fixed number of cycles.
- Inserts a fixed silent gap after each note, pulses done, then accepts the next note.
- Sits between the note-register/sequencer stage and the audio output pin.

Parameters:
- PERIOD_W, 16, width of half-period field in clk cycles
- DUR_W, 16, width of duration field in clk cycles
- GAP_CYCLES, 4, silent cycles after each note; 0 means no gap

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  synchronous, active-low reset (asserted when 0, sampled on rising clk)
- in_val  input  1  note fields valid
- in_rdy  output  1  block can accept a note
- in_half_period  input  PERIOD_W  square-wave half-period in cycles; 0 = rest (silence)
- in_duration  input  DUR_W  note length in cycles
- stop  input  1  abort current note, return to idle
- audio_out  output  1  square-wave output
- busy  output  1  high in PLAY or GAP
- done  output  1  one-cycle pulse when a note completes normally

Behaviour:
- Reset (rst==0 at an edge):
  - state=IDLE, audio_out=0, done=0, busy=0, in_rdy=1.
  - All counters and latched fields cleared.
  - Reset mid-note aborts with no done.
- States: IDLE, PLAY, GAP.
- IDLE:
  - in_rdy=1, busy=0, audio_out=0.
  - Handshake fires when in_val&in_rdy at an edge: latch half_period and duration, clear tone_cnt, dur_cnt=duration.
  - If duration!=0, go to PLAY. If duration==0, stay IDLE and assert done next cycle.
- PLAY:
  - Occupies exactly duration cycles; busy=1, in_rdy=0.
  - dur_cnt decrements each cycle. On the edge where dur_cnt==1, go to GAP (GAP_CYCLES>0) or to IDLE with done.
- Tone generation in PLAY:
  - audio_out starts 0 on the first PLAY cycle.
  - tone_cnt counts 0..half_period-1. On the edge where tone_cnt==half_period-1, audio_out toggles and tone_cnt clears.
  - half_period==1 toggles every cycle.
  - half_period==0: audio_out held 0 for the whole note (rest); duration still honoured.
- GAP:
  - audio_out=0, busy=1, in_rdy=0.
  - Lasts exactly GAP_CYCLES cycles, then IDLE with done.
- done:
  - High for exactly one cycle: the first IDLE cycle after normal completion.
  - in_rdy is also high that cycle, so a back-to-back note may be accepted on the same edge.
- stop:
  - Sampled at every edge.
  - In PLAY/GAP: next cycle state=IDLE, audio_out=0, no done.
  - In IDLE: stop has priority over in_val; no handshake that edge.
- Priority: rst > stop > normal transitions.
- Width rules: counters are exactly PERIOD_W/DUR_W bits. Maximum values (all ones) must work with no overflow or wrap.
- Inputs are ignored outside the handshake; latched fields hold for the whole note.

Decomposition:
- Package music_pkg:
  - state enum (IDLE, PLAY, GAP)
  - default width localparams PERIOD_W_DEF=16, DUR_W_DEF=16
  - constant REST_PERIOD=0
- One sub-module, tone_divider:
  - Inputs: clk, rst, en, half_period.
  - Output: audio.
  - Holds tone_cnt and the toggle flop; clears when en==0.
- note_player keeps the FSM, duration counter and gap counter.

Test Plan:
- Reset: drive rst=0 for 2 cycles with in_val=1 -> audio_out=0, in_rdy=1, busy=0, done=0; no note accepted.
- Basic note (half_period=2, duration=8, GAP_CYCLES=4):
  - audio_out over the 8 PLAY cycles = 0,0,1,1,0,0,1,1.
  - Then 4 cycles of 0 with busy=1.
  - done=1 for one cycle at cycle 13 after handshake.
- Rest note (half_period=0, duration=5) -> audio_out=0 for all cycles, busy=1 for 5+4 cycles, single done pulse.
- Back-to-back: hold in_val=1 with a second note (half_period=1, duration=3) -> accepted on the done cycle; audio_out=0,1,0 next.
- Stop mid-note (half_period=3, duration=20), assert stop at PLAY cycle 7 -> IDLE and audio_out=0 next cycle, no done; new note accepted afterward.
- Edge cases:
  - duration=0 -> done next cycle, no PLAY.
  - duration=0xFFFF with half_period=0xFFFF -> first toggle after 65535 cycles, busy held for 65535+GAP cycles.
  - rst=0 mid-GAP -> immediate IDLE, no done.
